// File: rtl/send_packet_pkg.sv
// Shared types and constants for the RAM-to-MAC packet sender.
// Holds the FSM state encoding and default widths.
package send_packet_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int LEN_W_DEF  = 11;
    localparam int WORD_W     = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LAT,
        S_SEND,
        S_DONE
    } state_e;

    function automatic logic [7:0] word_byte(
        input logic [WORD_W-1:0] w,
        input logic [1:0]        i
    );
        return w[{i, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/send_packet_1.sv
// Streams a packet of tx_len bytes from a 32-bit Avalon-MM RAM
// into an Avalon-ST byte FIFO, little-endian byte order per word.
module send_packet_1
    import send_packet_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk_original,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [LEN_W-1:0]  tx_len,
    output logic              tx_busy,
    output logic              tx_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_chipselect,
    output logic              ram_read,
    input  logic [WORD_W-1:0] ram_readdata,
    output logic [7:0]        ff_tx_data,
    output logic              ff_tx_sop,
    output logic              ff_tx_eop,
    output logic              ff_tx_wren,
    output logic              ff_tx_err,
    input  logic              ff_tx_rdy
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [1:0]          idx_q,   idx_d;
    logic [LEN_W-1:0]    len_q,   len_d;
    logic [WORD_W-1:0]   word_q,  word_d;
    logic                sop_q,   sop_d;

    logic                last_byte;

    always_ff @(posedge clk_original) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            word_q  <= '0;
            sop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            word_q  <= word_d;
            sop_q   <= sop_d;
        end
    end

    // len_q counts bytes still to transfer, so 1 marks the eop byte
    assign last_byte = (len_q == LEN_W'(1));

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        idx_d          = idx_q;
        len_d          = len_q;
        word_d         = word_q;
        sop_d          = sop_q;
        tx_done        = 1'b0;
        ram_addr       = '0;
        ram_chipselect = 1'b0;
        ram_read       = 1'b0;
        ff_tx_data     = 8'h00;
        ff_tx_sop      = 1'b0;
        ff_tx_eop      = 1'b0;
        ff_tx_wren     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (tx_start && (tx_len != '0)) begin
                    len_d   = tx_len;
                    addr_d  = '0;
                    idx_d   = '0;
                    sop_d   = 1'b1;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                ram_chipselect = 1'b1;
                ram_read       = 1'b1;
                ram_addr       = addr_q;
                state_d        = S_LAT;
            end
            S_LAT: begin
                word_d  = ram_readdata;
                state_d = S_SEND;
            end
            S_SEND: begin
                ff_tx_wren = 1'b1;
                ff_tx_data = word_byte(word_q, idx_q);
                ff_tx_sop  = sop_q;
                ff_tx_eop  = last_byte;
                if (ff_tx_rdy) begin
                    sop_d = 1'b0;
                    len_d = len_q - LEN_W'(1);
                    if (last_byte) begin
                        state_d = S_DONE;
                    end else if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_RD;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                tx_done = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_busy   = (state_q != S_IDLE);
    assign ff_tx_err = 1'b0;

endmodule
